// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the SAP clock run/stop/step sequencer.
// State encoding and the default debounce interval.
package clock_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_STOP   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_STEP   = 2'd2;
    localparam state_t ST_HALTED = 2'd3;

    // 5 ms at a 100 MHz sysclk
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

endpackage

// File: rtl/clock_ctrl_debounce.sv
// Step-button conditioner: 2-FF synchronizer, stability counter,
// and a one-cycle pulse on each accepted press.
module clock_ctrl_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // The count restarts whenever the synced level matches the accepted one.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// Run/stop/single-step sequencer gating the SAP CPU clock enables.
// Optional cycle counter enabled by defining CYCLE_COUNT_EN.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             tick_fall,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             hlt,
    input  logic             clr_halt,
    output logic             cpu_clken,
    output logic             cpu_clken2,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycles
);

    state_t state_q, state_d;
    logic   pair_q,   pair_d;
    logic   clken_q,  clken_d;
    logic   clken2_q, clken2_d;
    logic   press;
    logic   rise_ok;
    logic   fall_ok;

    clock_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .btn     (step_btn),
        .press   (press)
    );

    // A coincident tick_fall is dropped so a pair can never collapse.
    assign rise_ok = tick;
    assign fall_ok = tick_fall & ~tick;

    always_comb begin
        state_d  = state_q;
        clken_d  = 1'b0;
        clken2_d = 1'b0;
        unique case (state_q)
            ST_STOP: begin
                if (run_sw) begin
                    state_d = hlt ? ST_HALTED : ST_RUN;
                end else if (press) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                clken_d  = rise_ok & run_sw & ~hlt & ~pair_q;
                clken2_d = fall_ok & pair_q;
                // Leave only once no pair is left open.
                if (!(clken_d || (pair_q && !clken2_d))) begin
                    if (hlt) begin
                        state_d = ST_HALTED;
                    end else if (!run_sw) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STEP: begin
                clken_d  = rise_ok & ~pair_q;
                clken2_d = fall_ok & pair_q;
                if (clken2_d) begin
                    state_d = hlt ? ST_HALTED : ST_STOP;
                end
            end
            ST_HALTED: begin
                if (clr_halt && !hlt) begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_STOP;
        endcase
        pair_d = clken_d | (pair_q & ~clken2_d);
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_STOP;
            pair_q   <= 1'b0;
            clken_q  <= 1'b0;
            clken2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pair_q   <= pair_d;
            clken_q  <= clken_d;
            clken2_q <= clken2_d;
        end
    end

    assign cpu_clken  = clken_q;
    assign cpu_clken2 = clken2_q;
    assign running    = (state_q == ST_RUN);
    assign halted     = (state_q == ST_HALTED);

`ifdef CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clken_d) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycles = cnt_q;
`else
    assign cycles = '0;
`endif

endmodule
